// File: rtl/m0_shift_pkg.sv
// rtl/m0_shift_pkg.sv - shared types and encodings for the Thumb shift issue controller
package m0_shift_pkg;

    localparam logic [1:0] ST_LSL = 2'b00;
    localparam logic [1:0] ST_LSR = 2'b01;
    localparam logic [1:0] ST_ASR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_WB      = 2'd3
    } state_t;

    // inst[15:13] for shift-by-immediate, inst[15:10] / inst[9:6] for data-processing register ops
    localparam logic [2:0] OP_SHIFT_IMM = 3'b000;
    localparam logic [1:0] OP_IMM_RSVD  = 2'b11;
    localparam logic [5:0] OP_DP_REG    = 6'b010000;
    localparam logic [3:0] DP_LSL       = 4'b0010;
    localparam logic [3:0] DP_LSR       = 4'b0011;
    localparam logic [3:0] DP_ASR       = 4'b0100;

    typedef struct packed {
        logic       legal;
        logic       use_reg;
        logic [1:0] stype;
        logic [2:0] src;
        logic [2:0] amt_reg;
        logic [2:0] dst;
        logic [7:0] imm_amt;
    } decode_t;

endpackage

// File: rtl/thumb_shift_decode.sv
// rtl/thumb_shift_decode.sv - combinational decode of 16-bit Thumb shift encodings
module thumb_shift_decode
    import m0_shift_pkg::*;
(
    input  logic [15:0] inst,
    output decode_t     dec
);

    always_comb begin
        dec = '0;
        if (inst[15:13] == OP_SHIFT_IMM && inst[12:11] != OP_IMM_RSVD) begin
            dec.legal = 1'b1;
            dec.stype = inst[12:11];
            dec.src   = inst[5:3];
            dec.dst   = inst[2:0];
            // imm5 of zero means 32 for right shifts; LSL #0 is a plain move
            if (inst[10:6] == 5'd0 && inst[12:11] != ST_LSL)
                dec.imm_amt = 8'd32;
            else
                dec.imm_amt = {3'b000, inst[10:6]};
        end else if (inst[15:10] == OP_DP_REG) begin
            dec.use_reg = 1'b1;
            dec.src     = inst[2:0];
            dec.amt_reg = inst[5:3];
            dec.dst     = inst[2:0];
            case (inst[9:6])
                DP_LSL: begin dec.legal = 1'b1; dec.stype = ST_LSL; end
                DP_LSR: begin dec.legal = 1'b1; dec.stype = ST_LSR; end
                DP_ASR: begin dec.legal = 1'b1; dec.stype = ST_ASR; end
                default: dec.legal = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/shift_issue_ctrl.sv
// rtl/shift_issue_ctrl.sv - issues Thumb shifts to the shift unit and writes back Rd and N/Z/C
module shift_issue_ctrl
    import m0_shift_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic [15:0] inst,
    output logic        inst_ready,
    output logic        illegal,
    output logic [2:0]  rf_raddr0,
    output logic [2:0]  rf_raddr1,
    input  logic [31:0] rf_rdata0,
    input  logic [31:0] rf_rdata1,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        sh_en,
    output logic        sh_S,
    output logic [31:0] sh_Rm,
    output logic [7:0]  sh_operand2,
    output logic [1:0]  sh_stype,
    output logic        sh_carry_in,
    output logic        sh_zero_in,
    output logic        sh_neg_in,
    input  logic [31:0] sh_Rd,
    input  logic        sh_carry_out,
    input  logic        sh_zero_out,
    input  logic        sh_neg_out,
    output logic [2:0]  apsr_nzc
);

    state_t      state, state_nxt;
    decode_t     dec;
    logic        accept;
    logic        illegal_q;
    logic [31:0] rm_q;
    logic [7:0]  amt_q;
    logic [1:0]  stype_q;
    logic [2:0]  rd_q;
    logic [31:0] res_q;
    logic [2:0]  flags_q;
    logic [2:0]  apsr_q;

    // only the low byte of Rs is a shift amount
    logic unused_rdata1;
    assign unused_rdata1 = ^rf_rdata1[31:8];

    thumb_shift_decode u_decode (
        .inst (inst),
        .dec  (dec)
    );

    assign accept     = inst_valid & inst_ready;
    assign rf_raddr0  = dec.src;
    assign rf_raddr1  = dec.amt_reg;
    assign illegal    = illegal_q;

    assign sh_Rm       = rm_q;
    assign sh_operand2 = amt_q;
    assign sh_stype    = stype_q;
    assign sh_neg_in   = apsr_q[2];
    assign sh_zero_in  = apsr_q[1];
    assign sh_carry_in = apsr_q[0];
    assign apsr_nzc    = apsr_q;
    assign rf_waddr    = rd_q;
    assign rf_wdata    = res_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // sh_en decodes straight from state so an async reset drops it at once
    always_comb begin
        state_nxt  = state;
        inst_ready = 1'b0;
        sh_en      = 1'b0;
        sh_S       = 1'b0;
        rf_we      = 1'b0;
        case (state)
            S_IDLE: begin
                inst_ready = ~illegal_q;
                if (accept && dec.legal)
                    state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                sh_en     = 1'b1;
                sh_S      = 1'b1;
                state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                sh_en     = 1'b1;
                sh_S      = 1'b1;
                state_nxt = S_WB;
            end
            S_WB: begin
                rf_we     = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_q <= 1'b0;
            rm_q      <= '0;
            amt_q     <= '0;
            stype_q   <= ST_LSL;
            rd_q      <= '0;
            res_q     <= '0;
            flags_q   <= '0;
            apsr_q    <= '0;
        end else begin
            illegal_q <= accept & ~dec.legal;
            if (accept && dec.legal) begin
                rm_q    <= rf_rdata0;
                amt_q   <= dec.use_reg ? rf_rdata1[7:0] : dec.imm_amt;
                stype_q <= dec.stype;
                rd_q    <= dec.dst;
            end
            if (state == S_CAPTURE) begin
                res_q   <= sh_Rd;
                flags_q <= {sh_neg_out, sh_zero_out, sh_carry_out};
            end
            if (state == S_WB)
                apsr_q <= flags_q;
        end
    end

endmodule

// File: tb/tb_shift_issue_ctrl.sv
// tb/tb_shift_issue_ctrl.sv - directed scoreboard bench for shift_issue_ctrl
module tb_shift_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_valid = 1'b0;
    logic [15:0] inst = 16'h0;
    logic        inst_ready, illegal;
    logic [2:0]  rf_raddr0, rf_raddr1, rf_waddr;
    logic [31:0] rf_rdata0, rf_rdata1, rf_wdata;
    logic        rf_we;
    logic        sh_en, sh_S;
    logic [31:0] sh_Rm, sh_Rd;
    logic [7:0]  sh_operand2;
    logic [1:0]  sh_stype;
    logic        sh_carry_in, sh_zero_in, sh_neg_in;
    logic        sh_carry_out, sh_zero_out, sh_neg_out;
    logic [2:0]  apsr_nzc;

    logic [31:0] regs [8];

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
    } wb_t;
    wb_t q[$];

    int errors = 0;
    int checks = 0;
    int run_len = 0;

    always #5 clk = ~clk;

    shift_issue_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_ready   (inst_ready),
        .illegal      (illegal),
        .rf_raddr0    (rf_raddr0),
        .rf_raddr1    (rf_raddr1),
        .rf_rdata0    (rf_rdata0),
        .rf_rdata1    (rf_rdata1),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .sh_en        (sh_en),
        .sh_S         (sh_S),
        .sh_Rm        (sh_Rm),
        .sh_operand2  (sh_operand2),
        .sh_stype     (sh_stype),
        .sh_carry_in  (sh_carry_in),
        .sh_zero_in   (sh_zero_in),
        .sh_neg_in    (sh_neg_in),
        .sh_Rd        (sh_Rd),
        .sh_carry_out (sh_carry_out),
        .sh_zero_out  (sh_zero_out),
        .sh_neg_out   (sh_neg_out),
        .apsr_nzc     (apsr_nzc)
    );

    assign rf_rdata0 = regs[rf_raddr0];
    assign rf_rdata1 = regs[rf_raddr1];

    // ideal ARM shifter: returns {N, Z, C, result}
    function automatic logic [34:0] ideal(input logic [31:0] rm, input logic [7:0] amt,
                                          input logic [1:0] st, input logic c_in);
        logic [31:0] r;
        logic        c;
        int          a;
        a = int'(amt);
        if (a == 0) begin
            r = rm; c = c_in;
        end else if (st == 2'b00) begin
            if (a < 32) begin r = rm << a; c = rm[32 - a]; end
            else if (a == 32) begin r = 32'h0; c = rm[0]; end
            else begin r = 32'h0; c = 1'b0; end
        end else if (st == 2'b01) begin
            if (a < 32) begin r = rm >> a; c = rm[a - 1]; end
            else if (a == 32) begin r = 32'h0; c = rm[31]; end
            else begin r = 32'h0; c = 1'b0; end
        end else begin
            if (a < 32) begin r = $signed(rm) >>> a; c = rm[a - 1]; end
            else begin r = {32{rm[31]}}; c = rm[31]; end
        end
        return {r[31], (r == 32'h0), c, r};
    endfunction

    always_comb {sh_neg_out, sh_zero_out, sh_carry_out, sh_Rd} =
        ideal(sh_Rm, sh_operand2, sh_stype, sh_carry_in);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rf_we) begin
            if (q.size() == 0) begin
                check("unexpected_rf_we", 32'd1, 32'd0);
            end else begin
                wb_t e;
                e = q.pop_front();
                check("rf_waddr", {29'd0, rf_waddr}, {29'd0, e.addr});
                check("rf_wdata", rf_wdata, e.data);
            end
        end
        if (sh_en) begin
            run_len++;
        end else begin
            if (run_len > 0) check("sh_en_run_len", run_len, 2);
            run_len = 0;
        end
    end

    // called just after a falling edge; returns just after the falling edge once ready again
    task automatic run_inst(input logic [15:0] i, input bit legal, input logic [7:0] amt,
                            input logic [2:0] nzc, input bit hold);
        int n;
        inst = i;
        inst_valid = 1'b1;
        n = 0;
        while (!inst_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", {31'd0, inst_ready}, 32'd1);
        @(posedge clk);
        #1;
        if (!hold) inst_valid = 1'b0;
        @(negedge clk);
        if (legal) begin
            check("issue_en_s", {30'd0, sh_en, sh_S}, 32'd3);
            check("issue_amt", {24'd0, sh_operand2}, {24'd0, amt});
            check("issue_ready", {31'd0, inst_ready}, 32'd0);
            @(negedge clk);
            check("capture_en_we", {30'd0, sh_en, rf_we}, 32'd2);
            check("capture_ready", {31'd0, inst_ready}, 32'd0);
            @(negedge clk);
            check("wb_en_we", {30'd0, sh_en, rf_we}, 32'd1);
            check("wb_ready", {31'd0, inst_ready}, 32'd0);
            @(negedge clk);
            check("done_ready", {31'd0, inst_ready}, 32'd1);
            check("apsr_nzc", {29'd0, apsr_nzc}, {29'd0, nzc});
        end else begin
            check("illegal_pulse", {29'd0, illegal, inst_ready, sh_en}, 32'd4);
            @(negedge clk);
            check("illegal_end", {30'd0, illegal, inst_ready}, 32'd1);
            check("illegal_apsr", {29'd0, apsr_nzc}, {29'd0, nzc});
        end
    endtask

    initial begin
        for (int r = 0; r < 8; r++) regs[r] = 32'h0;
        regs[1] = 32'h9000000F;
        regs[2] = 32'h80000000;
        regs[3] = 32'h80000000;
        regs[4] = 32'hF0000000;
        regs[5] = 32'h00000104;
        regs[7] = 32'h80000001;

        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, inst_ready}, 32'd1);
        check("rst_ctrl", {28'd0, sh_en, sh_S, rf_we, illegal}, 32'd0);
        check("rst_apsr", {29'd0, apsr_nzc}, 32'd0);
        check("rst_operands", {22'd0, sh_stype, sh_operand2}, 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // LSLS r2,r1,#4
        q.push_back('{3'd2, 32'h000000F0});
        run_inst(16'h010A, 1'b1, 8'd4, 3'b001, 1'b0);
        // LSRS r0,r3,#32
        q.push_back('{3'd0, 32'h00000000});
        run_inst(16'h0818, 1'b1, 8'd32, 3'b011, 1'b0);
        // ASRS r4,r5 (register form)
        q.push_back('{3'd4, 32'hFF000000});
        run_inst(16'h412C, 1'b1, 8'd4, 3'b100, 1'b0);
        // RORS and ADDS-register are not shifts
        run_inst(16'h41C8, 1'b0, 8'd0, 3'b100, 1'b0);
        run_inst(16'h1800, 1'b0, 8'd0, 3'b100, 1'b0);

        // back to back with inst_valid held; MOVS must pass the carry through
        q.push_back('{3'd6, 32'h00000002});
        run_inst(16'h007E, 1'b1, 8'd1, 3'b001, 1'b1);
        q.push_back('{3'd1, 32'h80000000});
        run_inst(16'h0011, 1'b1, 8'd0, 3'b101, 1'b0);

        // reset during CAPTURE aborts LSLS r3,r7,#1
        inst = 16'h007B;
        inst_valid = 1'b1;
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_capture_en", {31'd0, sh_en}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("abort_sh_en", {31'd0, sh_en}, 32'd0);
        check("abort_we", {31'd0, rf_we}, 32'd0);
        check("abort_apsr", {29'd0, apsr_nzc}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready", {31'd0, inst_ready}, 32'd1);
        repeat (3) @(negedge clk);

        // LSRS r0,r5,#6 after recovery
        q.push_back('{3'd0, 32'h00000004});
        run_inst(16'h09A8, 1'b1, 8'd6, 3'b000, 1'b0);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
